// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for an 8-digit 7-segment display. One digit
// is driven per scan slot (nibble, digit index, enable). A double-buffered
// 32-bit frame is loaded over valid/ready, and a newly loaded frame is promoted
// to the displayed buffer only at a frame boundary, so digits never tear.
//
// Optional feature macro: BLINK_EN
//   defined   -> iBlinkMask port and a blink frame counter gate oEna
//   undefined -> oEna depends only on the slot phase and iDigitEn
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int SCAN_DIV   = 100000, // clk cycles per digit slot
  parameter int BLANK_CYC  = 1000,   // blanked cycles at the start of each slot
  parameter int NUM_DIGITS = 8,      // digits scanned, 1..8
  parameter int BLINK_DIV  = 250     // frames per blink half-period
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iValue,
  input  logic        iValid,
  output logic        oReady,
  input  logic [7:0]  iDigitEn,
`ifdef BLINK_EN
  input  logic [7:0]  iBlinkMask,
`endif
  output logic [3:0]  oData,
  output logic [2:0]  oSel,
  output logic        oEna,
  output logic        oFrameStart
);

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CNT_W-1:0] scanCnt, cntNext;
  logic [2:0]       digitIdx, idxNext;
  logic [0:0]       state, stateNext;
  logic [31:0]      activeFrame, pendingFrame;
  logic             pendingNext;
  logic             slotEnd, frameEnd, accept;
  logic             blinkOff, litNow;

  // Decode the next scan position, next FSM state and handshake for this cycle.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
    cntNext     = scanCnt + 1'b1;
    idxNext     = digitIdx;
    slotEnd     = (scanCnt == CNT_LAST);
    frameEnd    = slotEnd && (digitIdx == IDX_LAST);
    if (slotEnd) begin
      cntNext = '0;
      idxNext = frameEnd ? 3'd0 : digitIdx + 3'd1;
    end
    stateNext   = (cntNext >= BLANK_END) ? ST_SHOW : ST_BLANK;
    accept      = iValid && oReady;
    // A word accepted on the boundary cycle stays pending: the pending buffer
    // was empty, so nothing transfers and the new word waits a full frame.
    pendingNext = accept ? 1'b1 : (frameEnd ? 1'b0 : !oReady);
  end

`ifdef BLINK_EN
  localparam int               FC_W    = $clog2(2 * BLINK_DIV);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(2 * BLINK_DIV - 1);
  localparam logic [FC_W-1:0]  FC_OFF  = FC_W'(BLINK_DIV);

  logic [FC_W-1:0] frameCnt;

  // Count frame boundaries modulo two blink half-periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameCnt <= '0;
    end else if (frameEnd) begin
      frameCnt <= (frameCnt == FC_LAST) ? '0 : frameCnt + 1'b1;
    end
  end

  assign blinkOff = (frameCnt >= FC_OFF) && iBlinkMask[digitIdx];
`else
  assign blinkOff = 1'b0;
`endif

  assign litNow = (state == ST_SHOW) && iDigitEn[digitIdx] && !blinkOff;

  // Advance the slot counter, digit index and BLANK/SHOW state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanCnt  <= '0;
      digitIdx <= 3'd0;
      state    <= ST_BLANK;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      scanCnt  <= cntNext;
      digitIdx <= idxNext;
      state    <= stateNext;
    end
  end

  // Double buffer: accept into pending, promote to active at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both frame buffers are plain registers and are reset, so the first
      // frame after reset displays zeros instead of power-up garbage.
      activeFrame  <= '0;
      pendingFrame <= '0;
      oReady       <= 1'b1;
    end else begin
      if (accept) begin
        pendingFrame <= iValue;
      end
      if (frameEnd && !oReady) begin
        activeFrame <= pendingFrame;
      end
      oReady <= !pendingNext;
    end
  end

  // Registered display outputs; digit index and nibble change only at slot start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oData       <= 4'd0;
      oSel        <= 3'd0;
      oEna        <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      oFrameStart <= (scanCnt == '0) && (digitIdx == 3'd0);
      oEna        <= litNow;
      if (scanCnt == '0) begin
        oSel  <= digitIdx;
        oData <= activeFrame[{digitIdx, 2'b00} +: 4];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Self-checking bench for display_scan_ctrl (SCAN_DIV=4, BLANK_CYC=1,
// NUM_DIGITS=8, BLINK_DIV=2). The reference model derives every expected
// output from the number of clock edges since reset release with plain
// arithmetic, plus a record of the accepted word and the frame it appears in.
// Define BLINK_EN to exercise the blink feature.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int SCAN_DIV   = 4;
  localparam int BLANK_CYC  = 1;
  localparam int NUM_DIGITS = 8;
  localparam int BLINK_DIV  = 2;
  localparam int FRAME_LEN  = SCAN_DIV * NUM_DIGITS;
`ifdef BLINK_EN
  localparam bit BLINK_MODEL = 1'b1;
`else
  localparam bit BLINK_MODEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iValue = '0;
  logic        iValid = 1'b0;
  logic [7:0]  iDigitEn = 8'hFF;
  logic [7:0]  blinkMask = 8'h00;
  logic        oReady;
  logic [3:0]  oData;
  logic [2:0]  oSel;
  logic        oEna;
  logic        oFrameStart;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int          t;          // index of the last clock edge since reset release
  logic [31:0] curVal;     // word displayed in the current frame
  logic [31:0] pendVal;    // accepted word waiting for its frame
  bit          pendValid;
  int          pendShow;   // first frame in which pendVal is displayed
  bit          acc;        // last edge accepted a word
  logic [3:0]  expData;
  logic [2:0]  expSel;
  logic        expEna, expFs, expReady;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .NUM_DIGITS(NUM_DIGITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iValue     (iValue),
    .iValid     (iValid),
    .oReady     (oReady),
    .iDigitEn   (iDigitEn),
`ifdef BLINK_EN
    .iBlinkMask (blinkMask),
`endif
    .oData      (oData),
    .oSel       (oSel),
    .oEna       (oEna),
    .oFrameStart(oFrameStart)
  );

  task automatic modelReset();
    t         = -1;
    curVal    = '0;
    pendVal   = '0;
    pendValid = 1'b0;
    pendShow  = 0;
    acc       = 1'b0;
    expData   = '0;
    expSel    = '0;
    expEna    = 1'b0;
    expFs     = 1'b0;
    expReady  = 1'b1;
  endtask

  // Advance one clock edge, update the model with the inputs seen at that edge,
  // and return 1 time unit after the edge (outputs settled).
  task automatic step();
    int o, d, f;
    bit off;
    @(posedge clk);
    t++;
    o = t % SCAN_DIV;
    d = (t / SCAN_DIV) % NUM_DIGITS;
    f = t / FRAME_LEN;
    if (o == 0 && d == 0 && pendValid && pendShow <= f) begin
      curVal    = pendVal;
      pendValid = 1'b0;
    end
    acc = iValid && expReady;
    if (acc) begin
      pendVal   = iValue;
      pendShow  = (t + 1) / FRAME_LEN + 1;
      pendValid = 1'b1;
    end
    expSel = 3'(d);
    expFs  = (o == 0) && (d == 0);
    if (o == 0) expData = curVal[4*d +: 4];
    off      = BLINK_MODEL && ((f % (2 * BLINK_DIV)) >= BLINK_DIV) && blinkMask[d];
    expEna   = (o >= BLANK_CYC) && iDigitEn[d] && !off;
    expReady = !(pendValid && pendShow > (t + 1) / FRAME_LEN);
    #1;
  endtask

  task automatic test_reset();
    modelReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (oData !== 4'd0) begin mismatched++; $display("FAIL reset_data got %0h want 0", oData); end
    compared++; if (oSel !== 3'd0) begin mismatched++; $display("FAIL reset_sel got %0d want 0", oSel); end
    compared++; if (oEna !== 1'b0) begin mismatched++; $display("FAIL reset_ena got %b want 0", oEna); end
    compared++; if (oFrameStart !== 1'b0) begin mismatched++; $display("FAIL reset_fs got %b want 0", oFrameStart); end
    compared++; if (oReady !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", oReady); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // oSel steps every SCAN_DIV cycles, oEna is 0,1,1,1 per slot, oFrameStart every frame.
  task automatic test_scan();
    iDigitEn = 8'hFF;
    for (int i = 0; i < 2 * FRAME_LEN + 8; i++) begin
      step();
      compared++; if (oSel !== expSel) begin mismatched++; $display("FAIL scan_sel t=%0d got %0d want %0d", t, oSel, expSel); end
      compared++; if (oEna !== expEna) begin mismatched++; $display("FAIL scan_ena t=%0d got %b want %b", t, oEna, expEna); end
      compared++; if (oFrameStart !== expFs) begin mismatched++; $display("FAIL scan_fs t=%0d got %b want %b", t, oFrameStart, expFs); end
    end
  endtask

  // Single mid-frame load: hidden in the current frame, shown from the next.
  task automatic test_load();
    while (t % FRAME_LEN != FRAME_LEN / 2) step();
    iValue = 32'h87654321;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    compared++; if (acc !== 1'b1) begin mismatched++; $display("FAIL load_accept t=%0d got %b want 1", t, acc); end
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      compared++; if (oReady !== expReady) begin mismatched++; $display("FAIL load_ready t=%0d got %b want %b", t, oReady, expReady); end
      compared++; if (oData !== expData) begin mismatched++; $display("FAIL load_data t=%0d got %0h want %0h", t, oData, expData); end
    end
  endtask

  // iValid held high across two words: one accept per frame, nothing lost.
  task automatic test_back_to_back();
    int accepts = 0;
    iValue = 32'hA0A0A0A0;
    iValid = 1'b1;
    for (int i = 0; i < 5 * FRAME_LEN && accepts < 2; i++) begin
      step();
      if (acc) begin
        accepts++;
        if (accepts == 1) iValue = 32'hB1B1B1B1;
        else iValid = 1'b0;
      end
      compared++; if (oReady !== expReady) begin mismatched++; $display("FAIL b2b_ready t=%0d got %b want %b", t, oReady, expReady); end
      compared++; if (oData !== expData) begin mismatched++; $display("FAIL b2b_data t=%0d got %0h want %0h", t, oData, expData); end
    end
    iValid = 1'b0;
    compared++; if (accepts != 2) begin mismatched++; $display("FAIL b2b_accepts got %0d want 2", accepts); end
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      compared++; if (oData !== expData) begin mismatched++; $display("FAIL b2b_tail t=%0d got %0h want %0h", t, oData, expData); end
    end
  endtask

  // A word offered exactly on the boundary cycle appears one frame later.
  task automatic test_boundary();
    bit found = 1'b0;
    for (int i = 0; i < 4 * FRAME_LEN && !found; i++) begin
      step();
      found = expReady && (t % FRAME_LEN == FRAME_LEN - 2);
    end
    compared++; if (!found) begin mismatched++; $display("FAIL bnd_setup t=%0d got none want boundary", t); end
    iValue = 32'hC3C3C3C3;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    compared++; if (oReady !== 1'b0) begin mismatched++; $display("FAIL bnd_ready t=%0d got %b want 0", t, oReady); end
    for (int i = 0; i < 3 * FRAME_LEN; i++) begin
      step();
      compared++; if (oData !== expData) begin mismatched++; $display("FAIL bnd_data t=%0d got %0h want %0h", t, oData, expData); end
      compared++; if (oReady !== expReady) begin mismatched++; $display("FAIL bnd_ready2 t=%0d got %b want %b", t, oReady, expReady); end
    end
  endtask

  // Partial digit enable, then asynchronous reset in the middle of a slot.
  task automatic test_enable_reset();
    iDigitEn = 8'h05;
    for (int i = 0; i < FRAME_LEN + 3; i++) begin
      step();
      compared++; if (oEna !== expEna) begin mismatched++; $display("FAIL en_ena t=%0d got %b want %b", t, oEna, expEna); end
    end
    iValue = 32'h5A5A5A5A;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if ({oData, oSel, oEna, oFrameStart} !== 9'd0) begin mismatched++; $display("FAIL arst_out got %0h/%0d/%b/%b want 0", oData, oSel, oEna, oFrameStart); end
    compared++; if (oReady !== 1'b1) begin mismatched++; $display("FAIL arst_ready got %b want 1", oReady); end
    modelReset();
    iDigitEn = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME_LEN + 4; i++) begin
      step();
      compared++; if ({oData, oSel, oEna, oFrameStart, oReady} !== {expData, expSel, expEna, expFs, expReady}) begin
        mismatched++; $display("FAIL arst_after t=%0d got %0h/%0d/%b/%b/%b want %0h/%0d/%b/%b/%b", t, oData, oSel, oEna, oFrameStart, oReady, expData, expSel, expEna, expFs, expReady);
      end
    end
  endtask

  // Randomized producer traffic and digit enables against the model.
  task automatic test_random();
    for (int i = 0; i < 20 * FRAME_LEN; i++) begin
      iValid   = ($urandom_range(0, 3) == 0);
      iValue   = $urandom;
      iDigitEn = 8'($urandom);
      step();
      compared++; if ({oData, oSel, oEna, oFrameStart, oReady} !== {expData, expSel, expEna, expFs, expReady}) begin
        mismatched++; $display("FAIL rand t=%0d got %0h/%0d/%b/%b/%b want %0h/%0d/%b/%b/%b", t, oData, oSel, oEna, oFrameStart, oReady, expData, expSel, expEna, expFs, expReady);
      end
    end
    iValid   = 1'b0;
    iDigitEn = 8'hFF;
  endtask

`ifdef BLINK_EN
  // Digit 0 blinks: lit for BLINK_DIV frames, dark for BLINK_DIV frames.
  task automatic test_blink();
    blinkMask = 8'h01;
    iDigitEn  = 8'hFF;
    for (int i = 0; i < 8 * FRAME_LEN; i++) begin
      step();
      compared++; if (oEna !== expEna) begin mismatched++; $display("FAIL blink_ena t=%0d sel=%0d got %b want %b", t, oSel, oEna, expEna); end
    end
    blinkMask = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_boundary();
    test_enable_reset();
    test_random();
`ifdef BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
